// File: rtl/stream_prefetch_ctrl_pkg.sv
// Shared CPU definitions for the instruction-side next-line prefetch controller:
// physical address type, line/label typedefs and controller state encoding.
package stream_prefetch_ctrl_pkg;

  localparam int unsigned PHYS_WIDTH     = 32;
  typedef logic [PHYS_WIDTH-1:0] phys_t;

  localparam int unsigned LINE_WIDTH_DEF = 256;
  localparam int unsigned OFFSET_WIDTH   = $clog2(LINE_WIDTH_DEF / 8);
  localparam int unsigned LABEL_WIDTH    = $bits(phys_t) - OFFSET_WIDTH;

  typedef logic [LINE_WIDTH_DEF-1:0] line_t;
  typedef logic [LABEL_WIDTH-1:0]    label_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_FILL = 3'd3,
    ST_RESP      = 3'd4,
    ST_PREFETCH  = 3'd5
  } state_e;

endpackage

// File: rtl/stream_prefetch_ctrl.sv
// Next-line prefetch controller between the I-cache miss path and stream_buffer.
// Serves hits from the buffered line and keeps label+1 in flight after each delivery.
module stream_prefetch_ctrl
  import stream_prefetch_ctrl_pkg::*;
#(
  parameter int unsigned LINE_WIDTH  = LINE_WIDTH_DEF,
  parameter bit          PREFETCH_EN = 1'b1,
  parameter int unsigned CNT_WIDTH   = 32,
  localparam int unsigned LBL_W      = $bits(phys_t) - $clog2(LINE_WIDTH / 8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_req,
  input  logic [LBL_W-1:0]      miss_label,
  output logic                  miss_ready,
  output logic                  line_vld,
  output logic [LINE_WIDTH-1:0] line_data,
  output logic [LBL_W-1:0]      line_label,
  output logic [LBL_W-1:0]      sb_label_i,
  output logic                  sb_label_i_rdy,
  output logic                  sb_inv,
  input  logic [LBL_W-1:0]      sb_label_o,
  input  logic [LINE_WIDTH-1:0] sb_data,
  input  logic                  sb_data_vld,
  input  logic                  sb_ready,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt
);

  state_e                state_q, state_d;
  logic [LBL_W-1:0]      req_label_q, req_label_d;
  logic [LBL_W-1:0]      pend_label_q, pend_label_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [LBL_W-1:0]      sb_label_q, sb_label_d;
  logic                  sb_rdy_q, sb_rdy_d;
  logic                  sb_inv_q, sb_inv_d;
  logic                  miss_ready_q, miss_ready_d;
  logic                  line_vld_q, line_vld_d;
  logic [LINE_WIDTH-1:0] line_data_q, line_data_d;
  logic [LBL_W-1:0]      line_label_q, line_label_d;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;

  logic                  hit_inc;
  logic                  miss_inc;
  logic                  capture;
  logic                  buf_match;
  logic                  pend_match;
  logic [LBL_W-1:0]      next_label;

  assign buf_match  = sb_data_vld && (sb_label_o == req_label_q);
  assign pend_match = pend_vld_q && (pend_label_q == req_label_q) && !sb_data_vld;
  assign next_label = LBL_W'(req_label_q + 1'b1);

  // State register and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_label_q  <= '0;
      pend_label_q <= '0;
      pend_vld_q   <= 1'b0;
      sb_label_q   <= '0;
      sb_rdy_q     <= 1'b0;
      sb_inv_q     <= 1'b0;
      miss_ready_q <= 1'b1;
      line_vld_q   <= 1'b0;
      line_data_q  <= '0;
      line_label_q <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      req_label_q  <= req_label_d;
      pend_label_q <= pend_label_d;
      pend_vld_q   <= pend_vld_d;
      sb_label_q   <= sb_label_d;
      sb_rdy_q     <= sb_rdy_d;
      sb_inv_q     <= sb_inv_d;
      miss_ready_q <= miss_ready_d;
      line_vld_q   <= line_vld_d;
      line_data_q  <= line_data_d;
      line_label_q <= line_label_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Next state; pulses are decided one cycle early so they appear in the named state
  always_comb begin
    state_d      = state_q;
    req_label_d  = req_label_q;
    pend_label_d = pend_label_q;
    pend_vld_d   = pend_vld_q;
    sb_label_d   = sb_label_q;
    sb_rdy_d     = 1'b0;
    sb_inv_d     = 1'b0;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    capture      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (miss_req && miss_ready_q) begin
          req_label_d = miss_label;
          state_d     = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (buf_match) begin
          hit_inc = 1'b1;
          capture = 1'b1;
          state_d = ST_RESP;
        end else if (pend_match) begin
          hit_inc = 1'b1;
          state_d = ST_WAIT_FILL;
        end else begin
          sb_inv_d   = sb_data_vld || pend_vld_q;
          pend_vld_d = 1'b0;
          miss_inc   = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (sb_ready) begin
          sb_rdy_d     = 1'b1;
          sb_label_d   = req_label_q;
          pend_label_d = req_label_q;
          pend_vld_d   = 1'b1;
          state_d      = ST_WAIT_FILL;
        end
      end
      ST_WAIT_FILL: begin
        if (buf_match) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = PREFETCH_EN ? ST_PREFETCH : ST_IDLE;
      end
      ST_PREFETCH: begin
        if (sb_ready) begin
          sb_rdy_d     = 1'b1;
          sb_label_d   = next_label;
          pend_label_d = next_label;
          pend_vld_d   = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        pend_vld_d = 1'b0;
      end
    endcase

    // Delivered line is consumed, so the buffer copy is discarded alongside line_vld
    if (capture) begin
      sb_inv_d   = 1'b1;
      pend_vld_d = 1'b0;
    end
  end

  // Response payload and ready strobe
  always_comb begin
    miss_ready_d = (state_d == ST_IDLE);
    line_vld_d   = capture;
    line_data_d  = capture ? sb_data : line_data_q;
    line_label_d = capture ? req_label_q : line_label_q;
  end

  // Saturating perf counters
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_inc && (hit_cnt_q != '1)) begin
      hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
    end
    if (miss_inc && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign miss_ready     = miss_ready_q;
  assign line_vld       = line_vld_q;
  assign line_data      = line_data_q;
  assign line_label     = line_label_q;
  assign sb_label_i     = sb_label_q;
  assign sb_label_i_rdy = sb_rdy_q;
  assign sb_inv         = sb_inv_q;
  assign hit_cnt        = hit_cnt_q;
  assign miss_cnt       = miss_cnt_q;

endmodule

// File: tb/tb_stream_prefetch_ctrl.sv
// Directed bench for stream_prefetch_ctrl: two instances (prefetch on/off) each
// paired with a small fixed-latency stream_buffer model.
module tb_stream_prefetch_ctrl;

  localparam int unsigned LW       = 27;
  localparam int unsigned LINEW    = 256;
  localparam int unsigned CW       = 32;
  localparam int          FILL_LAT = 4;
  localparam int          BUDGET   = 200;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic             miss_req     [2];
  logic [LW-1:0]    miss_label   [2];
  logic             miss_ready   [2];
  logic             line_vld     [2];
  logic [LINEW-1:0] line_data    [2];
  logic [LW-1:0]    line_label   [2];
  logic [LW-1:0]    sb_label_i   [2];
  logic             sb_rdy       [2];
  logic             sb_inv       [2];
  logic [LW-1:0]    sb_label_o   [2];
  logic [LINEW-1:0] sb_data      [2];
  logic             sb_data_vld  [2];
  logic             sb_ready     [2];
  logic [CW-1:0]    hit_cnt      [2];
  logic [CW-1:0]    miss_cnt     [2];

  int               fill_cnt     [2];
  int               vld_cnt      [2];
  int               inv_cnt      [2];
  int               rdy_cnt      [2];
  int               overlap_cnt  [2];
  logic [LW-1:0]    last_issue   [2];
  logic [LW-1:0]    prev_issue   [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stream_prefetch_ctrl #(.LINE_WIDTH(LINEW), .PREFETCH_EN(1'b1), .CNT_WIDTH(CW)) u_dut (
    .clk(clk), .rst(rst),
    .miss_req(miss_req[0]), .miss_label(miss_label[0]), .miss_ready(miss_ready[0]),
    .line_vld(line_vld[0]), .line_data(line_data[0]), .line_label(line_label[0]),
    .sb_label_i(sb_label_i[0]), .sb_label_i_rdy(sb_rdy[0]), .sb_inv(sb_inv[0]),
    .sb_label_o(sb_label_o[0]), .sb_data(sb_data[0]), .sb_data_vld(sb_data_vld[0]),
    .sb_ready(sb_ready[0]), .hit_cnt(hit_cnt[0]), .miss_cnt(miss_cnt[0])
  );

  stream_prefetch_ctrl #(.LINE_WIDTH(LINEW), .PREFETCH_EN(1'b0), .CNT_WIDTH(CW)) u_dut_np (
    .clk(clk), .rst(rst),
    .miss_req(miss_req[1]), .miss_label(miss_label[1]), .miss_ready(miss_ready[1]),
    .line_vld(line_vld[1]), .line_data(line_data[1]), .line_label(line_label[1]),
    .sb_label_i(sb_label_i[1]), .sb_label_i_rdy(sb_rdy[1]), .sb_inv(sb_inv[1]),
    .sb_label_o(sb_label_o[1]), .sb_data(sb_data[1]), .sb_data_vld(sb_data_vld[1]),
    .sb_ready(sb_ready[1]), .hit_cnt(hit_cnt[1]), .miss_cnt(miss_cnt[1])
  );

  function automatic logic [LINEW-1:0] mem_line(input logic [LW-1:0] l);
    logic [LINEW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = {5'(i), l} ^ 32'hC3A5_0000;
    return r;
  endfunction

  // Stream buffer model: fetch lands FILL_LAT cycles after the start pulse
  always @(posedge clk or posedge rst) begin
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        sb_data_vld[c] <= 1'b0;
        sb_label_o[c]  <= '0;
        fill_cnt[c]    <= 0;
      end else if (sb_rdy[c]) begin
        sb_label_o[c]  <= sb_label_i[c];
        sb_data_vld[c] <= 1'b0;
        fill_cnt[c]    <= FILL_LAT;
      end else if (sb_inv[c]) begin
        sb_data_vld[c] <= 1'b0;
        fill_cnt[c]    <= 0;
      end else if (fill_cnt[c] != 0) begin
        fill_cnt[c] <= fill_cnt[c] - 1;
        if (fill_cnt[c] == 1) sb_data_vld[c] <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 2; c++) sb_data[c] = mem_line(sb_label_o[c]);
  end

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (line_vld[c]) vld_cnt[c] <= vld_cnt[c] + 1;
      if (sb_inv[c])   inv_cnt[c] <= inv_cnt[c] + 1;
      if (sb_rdy[c]) begin
        rdy_cnt[c]    <= rdy_cnt[c] + 1;
        prev_issue[c] <= last_issue[c];
        last_issue[c] <= sb_label_i[c];
      end
      if (sb_inv[c] && sb_rdy[c]) overlap_cnt[c] <= overlap_cnt[c] + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [LINEW-1:0] got, input logic [LINEW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input int c);
    int n;
    n = 0;
    while (!miss_ready[c] && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check_eq("miss_ready_wait", 256'(miss_ready[c]), 256'(1));
  endtask

  // One request end to end; lat = negedges from the cycle after accept until line_vld
  task automatic do_req(input int c, input logic [LW-1:0] lbl, output int lat);
    wait_ready(c);
    miss_req[c]   = 1'b1;
    miss_label[c] = lbl;
    @(negedge clk);
    miss_req[c] = 1'b0;
    lat = 0;
    while (!line_vld[c] && lat < BUDGET) begin
      @(negedge clk);
      lat++;
    end
    check_eq("line_vld", 256'(line_vld[c]), 256'(1));
    check_eq("line_data", line_data[c], mem_line(lbl));
    check_eq("line_label", 256'(line_label[c]), 256'(lbl));
    wait_ready(c);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int v0;
    int r0;
    int i0;
    int n;
    for (int c = 0; c < 2; c++) begin
      miss_req[c] = 1'b0; miss_label[c] = '0; sb_ready[c] = 1'b1;
      vld_cnt[c] = 0; inv_cnt[c] = 0; rdy_cnt[c] = 0; overlap_cnt[c] = 0;
      last_issue[c] = '0; prev_issue[c] = '0;
    end
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check_eq("rst_miss_ready", 256'(miss_ready[0]), 256'(1));
    check_eq("rst_line_vld", 256'(line_vld[0]), 256'(0));
    check_eq("rst_sb_rdy", 256'(sb_rdy[0]), 256'(0));
    check_eq("rst_sb_inv", 256'(sb_inv[0]), 256'(0));
    check_eq("rst_sb_label", 256'(sb_label_i[0]), 256'(0));
    check_eq("rst_hit_cnt", 256'(hit_cnt[0]), 256'(0));
    check_eq("rst_miss_cnt", 256'(miss_cnt[0]), 256'(0));

    // Cold miss
    do_req(0, 27'h0000100, lat);
    check_eq("cold_lat", 256'(lat), 256'(8));
    check_eq("cold_miss_cnt", 256'(miss_cnt[0]), 256'(1));
    check_eq("cold_hit_cnt", 256'(hit_cnt[0]), 256'(0));
    check_eq("cold_inv_cnt", 256'(inv_cnt[0]), 256'(1));
    check_eq("cold_vld_cnt", 256'(vld_cnt[0]), 256'(1));
    check_eq("cold_demand_lbl", 256'(prev_issue[0]), 256'(27'h0000100));
    check_eq("cold_pref_lbl", 256'(last_issue[0]), 256'(27'h0000101));

    // Sequential stream, each served from the in-flight prefetch
    for (int k = 1; k < 8; k++) do_req(0, LW'(32'h100 + k), lat);
    check_eq("seq_hit_cnt", 256'(hit_cnt[0]), 256'(7));
    check_eq("seq_miss_cnt", 256'(miss_cnt[0]), 256'(1));
    check_eq("seq_vld_cnt", 256'(vld_cnt[0]), 256'(8));
    check_eq("seq_rdy_cnt", 256'(rdy_cnt[0]), 256'(9));
    check_eq("seq_inv_cnt", 256'(inv_cnt[0]), 256'(8));

    // Landed prefetch: direct hit, line_vld two cycles after accept
    repeat (10) @(negedge clk);
    do_req(0, 27'h0000108, lat);
    check_eq("hit_lat", 256'(lat), 256'(1));
    check_eq("hit_hit_cnt", 256'(hit_cnt[0]), 256'(8));

    // Non-sequential request against a landed line
    repeat (10) @(negedge clk);
    do_req(0, 27'h0000300, lat);
    check_eq("nonseq_miss_cnt", 256'(miss_cnt[0]), 256'(2));
    check_eq("nonseq_inv_cnt", 256'(inv_cnt[0]), 256'(11));
    check_eq("nonseq_demand", 256'(prev_issue[0]), 256'(27'h0000300));
    check_eq("nonseq_pref", 256'(last_issue[0]), 256'(27'h0000301));

    // Label wrap, requested while the previous prefetch is still filling
    do_req(0, 27'h7FFFFFF, lat);
    check_eq("wrap_miss_cnt", 256'(miss_cnt[0]), 256'(3));
    check_eq("wrap_inv_cnt", 256'(inv_cnt[0]), 256'(13));
    check_eq("wrap_pref", 256'(last_issue[0]), 256'(27'h0000000));

    // sb_ready low stalls ISSUE with no pulses
    sb_ready[0] = 1'b0;
    r0 = rdy_cnt[0];
    miss_req[0] = 1'b1; miss_label[0] = 27'h0000500;
    @(negedge clk);
    miss_req[0] = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("stall_rdy_cnt", 256'(rdy_cnt[0]), 256'(r0));
    check_eq("stall_miss_ready", 256'(miss_ready[0]), 256'(0));
    check_eq("stall_miss_cnt", 256'(miss_cnt[0]), 256'(4));
    sb_ready[0] = 1'b1;
    n = 0;
    while (!line_vld[0] && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check_eq("stall_line_vld", 256'(line_vld[0]), 256'(1));
    check_eq("stall_line_data", line_data[0], mem_line(27'h0000500));
    wait_ready(0);
    @(negedge clk);
    check_eq("stall_pref", 256'(last_issue[0]), 256'(27'h0000501));

    // Asynchronous reset while waiting for a fill
    v0 = vld_cnt[0];
    miss_req[0] = 1'b1; miss_label[0] = 27'h0000600;
    @(negedge clk);
    miss_req[0] = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_miss_ready", 256'(miss_ready[0]), 256'(1));
    check_eq("arst_sb_label", 256'(sb_label_i[0]), 256'(0));
    check_eq("arst_line_data", line_data[0], 256'(0));
    check_eq("arst_line_label", 256'(line_label[0]), 256'(0));
    check_eq("arst_hit_cnt", 256'(hit_cnt[0]), 256'(0));
    check_eq("arst_miss_cnt", 256'(miss_cnt[0]), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("arst_no_vld", 256'(vld_cnt[0]), 256'(v0));
    i0 = inv_cnt[0];
    do_req(0, 27'h0000100, lat);
    check_eq("post_rst_lat", 256'(lat), 256'(8));
    check_eq("post_rst_miss", 256'(miss_cnt[0]), 256'(1));
    check_eq("post_rst_inv", 256'(inv_cnt[0] - i0), 256'(1));

    // Prefetch disabled: demand fetch only
    do_req(1, 27'h7FFFFFF, lat);
    check_eq("np_lat", 256'(lat), 256'(8));
    repeat (10) @(negedge clk);
    check_eq("np_rdy_cnt", 256'(rdy_cnt[1]), 256'(1));
    check_eq("np_miss_cnt", 256'(miss_cnt[1]), 256'(1));

    check_eq("pulse_overlap0", 256'(overlap_cnt[0]), 256'(0));
    check_eq("pulse_overlap1", 256'(overlap_cnt[1]), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
